// File: rtl/msi_coherence_controller.sv
// -----------------------------------------------------------------------------
// msi_coherence_controller
//
// Per-line MSI coherence decision logic for one private cache. Two fully
// independent paths are evaluated every cycle and their results registered:
//   - CPU path:   current state of the CPU-addressed line plus the CPU request
//                 qualifiers -> new line state, bus command to issue, and a
//                 victim write-back strobe.
//   - Snoop path: current state of the snooped line plus the remote request
//                 seen on the bus -> new line state, write-back strobe, and a
//                 memory-abort strobe (this cache supplies the data).
// All outputs are registered, so they reflect the inputs sampled at the
// previous rising edge of clk.
//
// Line states handled by both paths:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   INVALID  | line not present / not usable (encoding 2'b11 also lands here)
//   SHARED   | clean copy, other caches may hold it too
//   MODIFIED | only valid copy, dirty with respect to memory
//
// Ports
//   clk                   in   sole clock, rising edge
//   rst_n                 in   synchronous active-low reset
//   cpu_state_in  [1:0]   in   state of the CPU-addressed line
//   cpu_read_hit          in   CPU read, tag hit
//   cpu_read_miss         in   CPU read, tag miss (line is a victim)
//   cpu_write_hit         in   CPU write, tag hit
//   cpu_write_miss        in   CPU write, tag miss (line is a victim)
//   bus_state_in  [1:0]   in   state of the snooped line
//   bus_read_miss         in   remote read miss on a matching tag
//   bus_write_miss        in   remote write miss on a matching tag
//   bus_invalidate        in   remote invalidate on a matching tag
//   cpu_state_next [1:0]  out  new state for the CPU-addressed line
//   cpu_bus_next   [1:0]  out  bus command this cache issues
//   cpu_write_back        out  victim write-back strobe
//   bus_state_next [1:0]  out  new state for the snooped line
//   bus_write_back        out  snoop write-back strobe
//   bus_abort_mem_access  out  memory access cancelled, this cache supplies data
// -----------------------------------------------------------------------------
module msi_coherence_controller #(
    parameter logic [1:0] INVALID        = 2'b00,
    parameter logic [1:0] MODIFIED       = 2'b01,
    parameter logic [1:0] SHARED         = 2'b10,
    parameter logic [1:0] BUS_INVALIDATE = 2'b00,
    parameter logic [1:0] BUS_WRITE_MISS = 2'b01,
    parameter logic [1:0] BUS_READ_MISS  = 2'b10,
    parameter logic [1:0] BUS_NONE       = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cpu_state_in,
    input  logic       cpu_read_hit,
    input  logic       cpu_read_miss,
    input  logic       cpu_write_hit,
    input  logic       cpu_write_miss,
    input  logic [1:0] bus_state_in,
    input  logic       bus_read_miss,
    input  logic       bus_write_miss,
    input  logic       bus_invalidate,
    output logic [1:0] cpu_state_next,
    output logic [1:0] cpu_bus_next,
    output logic       cpu_write_back,
    output logic [1:0] bus_state_next,
    output logic       bus_write_back,
    output logic       bus_abort_mem_access
);

    // Any encoding that is neither MODIFIED nor SHARED (including the unused
    // 2'b11) is handled as INVALID, so a corrupted tag state can never be
    // mistaken for an owned line.
    function automatic logic [1:0] norm_state(input logic [1:0] s);
        if (s == MODIFIED || s == SHARED) begin
            return s;
        end
        return INVALID;
    endfunction

    logic [1:0] cpu_state_eff;
    logic [1:0] bus_state_eff;

    logic [1:0] cpu_state_c;
    logic [1:0] cpu_bus_c;
    logic       cpu_wb_c;

    logic [1:0] bus_state_c;
    logic       bus_wb_c;
    logic       bus_abort_c;

    assign cpu_state_eff = norm_state(cpu_state_in);
    assign bus_state_eff = norm_state(bus_state_in);

    // CPU path. Qualifier priority: write_miss > write_hit > read_miss > read_hit.
    always_comb begin
        cpu_state_c = cpu_state_eff;
        cpu_bus_c   = BUS_NONE;
        cpu_wb_c    = 1'b0;

        if (cpu_write_miss) begin
            cpu_state_c = MODIFIED;
            cpu_bus_c   = BUS_WRITE_MISS;
            // Evicting a dirty victim must push it to memory first.
            cpu_wb_c    = (cpu_state_eff == MODIFIED);
        end else if (cpu_write_hit) begin
            cpu_state_c = MODIFIED;
            if (cpu_state_eff == SHARED) begin
                cpu_bus_c = BUS_INVALIDATE;
            end else if (cpu_state_eff == MODIFIED) begin
                cpu_bus_c = BUS_NONE;
            end else begin
                // A "hit" on an invalid line is really a miss.
                cpu_bus_c = BUS_WRITE_MISS;
            end
        end else if (cpu_read_miss) begin
            cpu_state_c = SHARED;
            cpu_bus_c   = BUS_READ_MISS;
            cpu_wb_c    = (cpu_state_eff == MODIFIED);
        end else if (cpu_read_hit) begin
            if (cpu_state_eff == INVALID) begin
                cpu_state_c = SHARED;
                cpu_bus_c   = BUS_READ_MISS;
            end else begin
                // SHARED and MODIFIED both satisfy a read locally.
                cpu_state_c = cpu_state_eff;
                cpu_bus_c   = BUS_NONE;
            end
        end
    end

    // Snoop path. Request priority: write_miss > invalidate > read_miss.
    // Only a MODIFIED line holds data memory lacks, so only it writes back
    // and cancels the memory access.
    always_comb begin
        bus_state_c = bus_state_eff;
        bus_wb_c    = 1'b0;
        bus_abort_c = 1'b0;

        if (bus_write_miss || bus_invalidate) begin
            bus_state_c = INVALID;
            bus_wb_c    = (bus_state_eff == MODIFIED);
            bus_abort_c = (bus_state_eff == MODIFIED);
        end else if (bus_read_miss) begin
            if (bus_state_eff == INVALID) begin
                bus_state_c = INVALID;
            end else begin
                bus_state_c = SHARED;
            end
            bus_wb_c    = (bus_state_eff == MODIFIED);
            bus_abort_c = (bus_state_eff == MODIFIED);
        end
    end

    // Output registers. Strobes are recomputed every cycle, so each stays
    // high exactly as long as qualifying events keep being sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_state_next       <= INVALID;
            cpu_bus_next         <= BUS_NONE;
            cpu_write_back       <= 1'b0;
            bus_state_next       <= INVALID;
            bus_write_back       <= 1'b0;
            bus_abort_mem_access <= 1'b0;
        end else begin
            cpu_state_next       <= cpu_state_c;
            cpu_bus_next         <= cpu_bus_c;
            cpu_write_back       <= cpu_wb_c;
            bus_state_next       <= bus_state_c;
            bus_write_back       <= bus_wb_c;
            bus_abort_mem_access <= bus_abort_c;
        end
    end

endmodule

// File: tb/tb_msi_coherence_controller.sv
// Directed and randomized bench for msi_coherence_controller. Expected values
// come from transition tables indexed by (line state, winning request).
module tb_msi_coherence_controller;

    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_M = 2'b01;
    localparam logic [1:0] S_S = 2'b10;
    localparam logic [1:0] B_INV  = 2'b00;
    localparam logic [1:0] B_WM   = 2'b01;
    localparam logic [1:0] B_RM   = 2'b10;
    localparam logic [1:0] B_NONE = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cpu_state_in;
    logic       cpu_read_hit, cpu_read_miss, cpu_write_hit, cpu_write_miss;
    logic [1:0] bus_state_in;
    logic       bus_read_miss, bus_write_miss, bus_invalidate;
    logic [1:0] cpu_state_next;
    logic [1:0] cpu_bus_next;
    logic       cpu_write_back;
    logic [1:0] bus_state_next;
    logic       bus_write_back;
    logic       bus_abort_mem_access;

    int errors = 0;
    int checks = 0;

    // cpu_tbl[state][req] = {new_state, bus_cmd, write_back}
    //   req: 0 read_hit, 1 read_miss, 2 write_hit, 3 write_miss
    logic [4:0] cpu_tbl [0:3][0:3];
    // snp_tbl[state][req] = {new_state, write_back, abort}
    //   req: 0 read_miss, 1 invalidate, 2 write_miss
    logic [3:0] snp_tbl [0:3][0:2];

    msi_coherence_controller dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cpu_state_in         (cpu_state_in),
        .cpu_read_hit         (cpu_read_hit),
        .cpu_read_miss        (cpu_read_miss),
        .cpu_write_hit        (cpu_write_hit),
        .cpu_write_miss       (cpu_write_miss),
        .bus_state_in         (bus_state_in),
        .bus_read_miss        (bus_read_miss),
        .bus_write_miss       (bus_write_miss),
        .bus_invalidate       (bus_invalidate),
        .cpu_state_next       (cpu_state_next),
        .cpu_bus_next         (cpu_bus_next),
        .cpu_write_back       (cpu_write_back),
        .bus_state_next       (bus_state_next),
        .bus_write_back       (bus_write_back),
        .bus_abort_mem_access (bus_abort_mem_access)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] cs, input logic [3:0] cq,
                          input logic [1:0] bs, input logic [2:0] bq);
        cpu_state_in = cs;
        {cpu_write_miss, cpu_write_hit, cpu_read_miss, cpu_read_hit} = cq;
        bus_state_in = bs;
        {bus_write_miss, bus_invalidate, bus_read_miss} = bq;
    endtask

    // Computes expectation from current inputs, clocks once, compares.
    task automatic step(input string tag);
        logic [1:0] e_cs, e_cb, e_bs;
        logic       e_cw, e_bw, e_ba;
        int         r;
        if (!rst_n) begin
            {e_cs, e_cb, e_cw} = {S_I, B_NONE, 1'b0};
            {e_bs, e_bw, e_ba} = {S_I, 1'b0, 1'b0};
        end else begin
            r = cpu_write_miss ? 3 : cpu_write_hit ? 2 : cpu_read_miss ? 1 : cpu_read_hit ? 0 : -1;
            if (r < 0) {e_cs, e_cb, e_cw} = {cpu_state_in, B_NONE, 1'b0};
            else       {e_cs, e_cb, e_cw} = cpu_tbl[cpu_state_in][r];
            r = bus_write_miss ? 2 : bus_invalidate ? 1 : bus_read_miss ? 0 : -1;
            if (r < 0) {e_bs, e_bw, e_ba} = {bus_state_in, 1'b0, 1'b0};
            else       {e_bs, e_bw, e_ba} = snp_tbl[bus_state_in][r];
        end
        @(posedge clk);
        #1;
        chk({tag, ".cpu_state"}, cpu_state_next, e_cs);
        chk({tag, ".cpu_bus"},   cpu_bus_next,   e_cb);
        chk({tag, ".cpu_wb"},    {1'b0, cpu_write_back}, {1'b0, e_cw});
        chk({tag, ".bus_state"}, bus_state_next, e_bs);
        chk({tag, ".bus_wb"},    {1'b0, bus_write_back}, {1'b0, e_bw});
        chk({tag, ".bus_abort"}, {1'b0, bus_abort_mem_access}, {1'b0, e_ba});
    endtask

    initial begin
        logic [1:0] cs, bs;
        logic [3:0] cq;
        logic [2:0] bq;

        // Tables: illegal state 3 behaves exactly like INVALID.
        for (int s = 0; s < 4; s++) begin
            for (int q = 0; q < 4; q++) begin
                if (s == 1) begin
                    cpu_tbl[s][q] = (q == 1) ? {S_S, B_RM, 1'b1} :
                                    (q == 3) ? {S_M, B_WM, 1'b1} : {S_M, B_NONE, 1'b0};
                end else if (s == 2) begin
                    cpu_tbl[s][q] = (q == 0) ? {S_S, B_NONE, 1'b0} :
                                    (q == 1) ? {S_S, B_RM, 1'b0} :
                                    (q == 2) ? {S_M, B_INV, 1'b0} : {S_M, B_WM, 1'b0};
                end else begin
                    cpu_tbl[s][q] = (q < 2) ? {S_S, B_RM, 1'b0} : {S_M, B_WM, 1'b0};
                end
            end
            for (int q = 0; q < 3; q++) begin
                if (s == 1)      snp_tbl[s][q] = (q == 0) ? {S_S, 2'b11} : {S_I, 2'b11};
                else if (s == 2) snp_tbl[s][q] = (q == 0) ? {S_S, 2'b00} : {S_I, 2'b00};
                else             snp_tbl[s][q] = {S_I, 2'b00};
            end
        end

        // Reset with every qualifier high, two cycles.
        rst_n = 1'b0;
        set_in(S_M, 4'hF, S_M, 3'h7);
        #1;
        step("reset0");
        step("reset1");
        rst_n = 1'b1;

        set_in(S_S, 4'b0100, S_I, 3'b000); step("cpu_wh_shared");
        set_in(S_M, 4'b0010, S_I, 3'b000); step("cpu_rm_mod");
        set_in(S_S, 4'b0000, S_I, 3'b000); step("wb_drops");
        set_in(S_I, 4'b0000, S_M, 3'b001); step("snp_rm_mod");
        set_in(S_I, 4'b0000, S_S, 3'b100); step("snp_wm_shared");
        set_in(S_I, 4'b1000, S_S, 3'b010); step("simultaneous");
        set_in(2'b11, 4'b0001, S_I, 3'b000); step("illegal_rh");
        set_in(S_S, 4'b1111, 2'b11, 3'b111); step("all_cpu_quals");
        // Repeated dirty events keep strobes high on consecutive cycles.
        set_in(S_M, 4'b1000, S_M, 3'b010); step("repeat0");
        step("repeat1");
        // Reset mid-operation discards the pending event.
        rst_n = 1'b0; step("mid_reset");
        rst_n = 1'b1; step("resume");

        for (int i = 0; i < 400; i++) begin
            cq = 4'($urandom_range(0, 15));
            bq = 3'($urandom_range(0, 7));
            cs = 2'($urandom_range(0, 3));
            bs = 2'($urandom_range(0, 3));
            // Leave the illegal encoding out of the pass-through case.
            if (cq == 4'h0 && cs == 2'b11) cs = 2'($urandom_range(0, 2));
            if (bq == 3'h0 && bs == 2'b11) bs = 2'($urandom_range(0, 2));
            set_in(cs, cq, bs, bq);
            rst_n = ($urandom_range(0, 19) != 0);
            step("random");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msi_coherence_controller.md
MSI_COHERENCE_CONTROLLER -- requirements
Module: msi_coherence_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 cpu_state_in  input  2  current coherency state of the CPU-addressed line.
REQ-005 cpu_read_hit, cpu_read_miss, cpu_write_hit, cpu_write_miss  input  1 each  CPU request qualifiers.
REQ-006 bus_state_in  input  2  current coherency state of the snooped line.
REQ-007 bus_read_miss, bus_write_miss, bus_invalidate  input  1 each  snooped remote requests; asserted only on a tag match.
REQ-008 cpu_state_next  output  2  new state for the CPU-addressed line.
REQ-009 cpu_bus_next  output  2  request this cache places on the bus.
REQ-010 cpu_write_back  output  1  CPU-side victim write-back strobe.
REQ-011 bus_state_next  output  2  new state for the snooped line.
REQ-012 bus_write_back  output  1  snoop-side write-back strobe.
REQ-013 bus_abort_mem_access  output  1  this cache supplies the data, so memory access is cancelled.
REQ-014 Parameters, name / default / meaning:
- INVALID / 2'b00 / state encoding.
- MODIFIED / 2'b01 / state encoding.
- SHARED / 2'b10 / state encoding.
- BUS_INVALIDATE / 2'b00 / bus command.
- BUS_WRITE_MISS / 2'b01 / bus command.
- BUS_READ_MISS / 2'b10 / bus command.
- BUS_NONE / 2'b11 / no bus command.

Function
REQ-015 All outputs SHALL be registered, with a latency of 1 cycle: outputs reflect the inputs sampled at the previous rising edge.
REQ-016 A state input of 2'b11 SHALL be treated as INVALID.
REQ-017 CPU qualifier priority SHALL be write_miss > write_hit > read_miss > read_hit.
REQ-018 With no CPU qualifier asserted, the CPU side SHALL load cpu_state_next = cpu_state_in, cpu_bus_next = BUS_NONE and cpu_write_back = 0.
REQ-019 CPU side, INVALID line:
- Any read qualifier -> SHARED, BUS_READ_MISS.
- Any write qualifier -> MODIFIED, BUS_WRITE_MISS.
- No write-back.
REQ-020 CPU side, SHARED line:
- read_hit -> SHARED, BUS_NONE.
- read_miss -> SHARED, BUS_READ_MISS.
- write_hit -> MODIFIED, BUS_INVALIDATE.
- write_miss -> MODIFIED, BUS_WRITE_MISS.
- No write-back.
REQ-021 CPU side, MODIFIED line:
- read_hit or write_hit -> MODIFIED, BUS_NONE, no write-back.
- read_miss -> SHARED, BUS_READ_MISS, cpu_write_back = 1.
- write_miss -> MODIFIED, BUS_WRITE_MISS, cpu_write_back = 1.
REQ-022 Snoop priority SHALL be write_miss > invalidate > read_miss.
REQ-023 With no snoop input asserted, the snoop side SHALL load bus_state_next = bus_state_in, bus_write_back = 0 and bus_abort_mem_access = 0.
REQ-024 Snoop side, INVALID line: any request -> INVALID, no write-back, no abort.
REQ-025 Snoop side, SHARED line:
- read_miss -> SHARED.
- write_miss or invalidate -> INVALID.
- No write-back, no abort.
REQ-026 Snoop side, MODIFIED line:
- read_miss -> SHARED, bus_write_back = 1, abort = 1.
- write_miss -> INVALID, bus_write_back = 1, abort = 1.
- invalidate -> INVALID, bus_write_back = 1, abort = 1.
REQ-027 The CPU and snoop paths SHALL be independent and evaluated in the same cycle; simultaneous CPU and snoop events SHALL both be processed without interaction.
REQ-028 cpu_write_back, bus_write_back and bus_abort_mem_access SHALL each be high for exactly one cycle per qualifying sampled event, and SHALL stay high on consecutive cycles if events repeat.

Reset
REQ-029 While rst_n = 0 at a rising edge, the registered outputs SHALL load the following values, overriding all inputs:
- cpu_state_next = INVALID.
- cpu_bus_next = BUS_NONE.
- bus_state_next = INVALID.
- cpu_write_back, bus_write_back, bus_abort_mem_access = 0.
REQ-030 A reset asserted mid-operation SHALL discard the pending event, and normal sampling SHALL resume at the first edge with rst_n = 1.

Verification
REQ-031 Reset: rst_n = 0 for 2 cycles with all qualifiers = 1 -> outputs 00/11/00/0/0/0.
REQ-032 CPU write_hit on SHARED (cpu_state_in = 10) -> next cycle cpu_state_next = 01, cpu_bus_next = 00, cpu_write_back = 0.
REQ-033 CPU read_miss on MODIFIED (01) -> cpu_state_next = 10, cpu_bus_next = 10, cpu_write_back = 1 for one cycle.
REQ-034 Snoop read_miss on MODIFIED -> bus_state_next = 10, bus_write_back = 1, bus_abort_mem_access = 1; snoop write_miss on SHARED -> bus_state_next = 00, strobes 0.
REQ-035 Simultaneous CPU write_miss on INVALID and snoop invalidate on SHARED -> cpu_state_next = 01, cpu_bus_next = 01, bus_state_next = 00.
REQ-036 Illegal state 11 with CPU read_hit -> cpu_state_next = 10, cpu_bus_next = 10; all four CPU qualifiers high on SHARED -> write_miss wins: 01/01.
